// File: rtl/vga_pkg.sv
// Shared VGA definitions: maximum interval widths and the supported resolution list.
package vga_pkg;

    localparam int VGA_MAX_H_WIDTH = 11;
    localparam int VGA_MAX_V_WIDTH = 10;

    typedef enum logic [1:0] {
        VGA_RES_640_480  = 2'd0,
        VGA_RES_800_600  = 2'd1,
        VGA_RES_1024_768 = 2'd2
    } vga_resolution_e;

    localparam int VGA_RES_NUM = 3;

    // Width needed to sum four W-bit intervals without wrapping.
    function automatic int vga_sum_width(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/vga_timing_io_if.sv
// One timing axis worth of signals: four intervals plus load strobe in, registered
// intervals and derived boundaries out.
interface vga_timing_io_if
    import vga_pkg::*;
#(
    parameter int W = VGA_MAX_H_WIDTH
);
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] f;
    logic [W-1:0] r;
    logic [W-1:0] b;

    logic [W-1:0] d_q;
    logic [W-1:0] f_q;
    logic [W-1:0] r_q;
    logic [W-1:0] b_q;
    logic [W-1:0] total;
    logic [W-1:0] sync_start;
    logic [W-1:0] sync_end;

    // The side supplying a timing set.
    modport master (
        output load, d, f, r, b,
        input  d_q, f_q, r_q, b_q, total, sync_start, sync_end
    );

    // The side holding the set and producing derived values.
    modport slave (
        input  load, d, f, r, b,
        output d_q, f_q, r_q, b_q, total, sync_start, sync_end
    );
endinterface

// File: rtl/vga_timing_axis.sv
// One axis (H or V): field registers, boundary adders, derived registers and the
// per-axis illegal flag.
module vga_timing_axis
    import vga_pkg::*;
#(
    parameter int W = VGA_MAX_H_WIDTH
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    vga_timing_io_if.slave   bus,
    output logic             ill_o
);

    localparam int SW = vga_sum_width(W);

    logic [W-1:0]  d_q, f_q, r_q, b_q;
    logic [W-1:0]  total_q, sync_start_q, sync_end_q;
    logic [SW-1:0] sync_start_d, sync_end_d, total_d;

    // Capture the four intervals on the load strobe, hold otherwise.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            d_q <= '0;
            f_q <= '0;
            r_q <= '0;
            b_q <= '0;
        end else if (bus.load) begin
            d_q <= bus.d;
            f_q <= bus.f;
            r_q <= bus.r;
            b_q <= bus.b;
        end
    end

    // Boundary sums at full width so overflow is visible.
    always_comb begin
        sync_start_d = {2'b00, d_q} + {2'b00, f_q};
        sync_end_d   = sync_start_d + {2'b00, r_q};
        total_d      = sync_end_d + {2'b00, b_q};
    end

    // Derived registers follow the field registers one cycle later.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            total_q      <= '0;
            sync_start_q <= '0;
            sync_end_q   <= '0;
        end else begin
            total_q      <= total_d[W-1:0];
            sync_start_q <= sync_start_d[W-1:0];
            sync_end_q   <= sync_end_d[W-1:0];
        end
    end

    // Sync boundaries never exceed the total, so folding their carry bits in
    // does not change the result; only the total overflow really matters.
    assign ill_o = (d_q == '0) || (r_q == '0) ||
                   (|{total_d[SW-1:W], sync_end_d[SW-1:W], sync_start_d[SW-1:W]});

    assign bus.d_q        = d_q;
    assign bus.f_q        = f_q;
    assign bus.r_q        = r_q;
    assign bus.b_q        = b_q;
    assign bus.total      = total_q;
    assign bus.sync_start = sync_start_q;
    assign bus.sync_end   = sync_end_q;

endmodule

// File: rtl/vga_timing_io.sv
// Registered VGA timing set: captures H/V intervals, derives totals and sync
// boundaries, and flags the set valid or illegal two cycles after a load.
module vga_timing_io
    import vga_pkg::*;
#(
    parameter int H_W = VGA_MAX_H_WIDTH,
    parameter int V_W = VGA_MAX_V_WIDTH
) (
    input  logic           clk_i,
    input  logic           arstn_i,
    input  logic           load_i,
    input  logic [H_W-1:0] hd_i,
    input  logic [H_W-1:0] hf_i,
    input  logic [H_W-1:0] hr_i,
    input  logic [H_W-1:0] hb_i,
    input  logic [V_W-1:0] vd_i,
    input  logic [V_W-1:0] vf_i,
    input  logic [V_W-1:0] vr_i,
    input  logic [V_W-1:0] vb_i,
    output logic [H_W-1:0] hd_o,
    output logic [H_W-1:0] hf_o,
    output logic [H_W-1:0] hr_o,
    output logic [H_W-1:0] hb_o,
    output logic [V_W-1:0] vd_o,
    output logic [V_W-1:0] vf_o,
    output logic [V_W-1:0] vr_o,
    output logic [V_W-1:0] vb_o,
    output logic [H_W-1:0] h_total_o,
    output logic [H_W-1:0] h_sync_start_o,
    output logic [H_W-1:0] h_sync_end_o,
    output logic [V_W-1:0] v_total_o,
    output logic [V_W-1:0] v_sync_start_o,
    output logic [V_W-1:0] v_sync_end_o,
    output logic           valid_o,
    output logic           err_o
);

    vga_timing_io_if #(.W(H_W)) h_bus ();
    vga_timing_io_if #(.W(V_W)) v_bus ();

    logic h_ill, v_ill, ill;
    logic pend_q, pend_d;
    logic valid_q, valid_d;
    logic err_q, err_d;

    assign h_bus.load = load_i;
    assign h_bus.d    = hd_i;
    assign h_bus.f    = hf_i;
    assign h_bus.r    = hr_i;
    assign h_bus.b    = hb_i;
    assign v_bus.load = load_i;
    assign v_bus.d    = vd_i;
    assign v_bus.f    = vf_i;
    assign v_bus.r    = vr_i;
    assign v_bus.b    = vb_i;

    vga_timing_axis #(.W(H_W)) u_h_axis (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .bus     (h_bus.slave),
        .ill_o   (h_ill)
    );

    vga_timing_axis #(.W(V_W)) u_v_axis (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .bus     (v_bus.slave),
        .ill_o   (v_ill)
    );

    assign ill = h_ill | v_ill;

    // A load arms the pending bit and clears the result; the cycle after the
    // last load the field registers are settled and the flags are resolved.
    always_comb begin
        pend_d  = load_i;
        valid_d = valid_q;
        err_d   = err_q;
        if (load_i) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (pend_q) begin
            valid_d = ~ill;
            err_d   = ill;
        end
    end

    // Result pipeline registers; reset drops any pending result.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign hd_o           = h_bus.d_q;
    assign hf_o           = h_bus.f_q;
    assign hr_o           = h_bus.r_q;
    assign hb_o           = h_bus.b_q;
    assign vd_o           = v_bus.d_q;
    assign vf_o           = v_bus.f_q;
    assign vr_o           = v_bus.r_q;
    assign vb_o           = v_bus.b_q;
    assign h_total_o      = h_bus.total;
    assign h_sync_start_o = h_bus.sync_start;
    assign h_sync_end_o   = h_bus.sync_end;
    assign v_total_o      = v_bus.total;
    assign v_sync_start_o = v_bus.sync_start;
    assign v_sync_end_o   = v_bus.sync_end;
    assign valid_o        = valid_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_vga_timing_io.sv
// Bench for vga_timing_io: scenario tasks with inline checks plus a result
// scoreboard that compares each new valid/err result against a model.
module tb_vga_timing_io;
    import vga_pkg::*;

    localparam int HW = VGA_MAX_H_WIDTH;
    localparam int VW = VGA_MAX_V_WIDTH;

    logic clk = 1'b0;
    logic arstn;
    logic valid, err;

    vga_timing_io_if #(.W(HW)) hb ();
    vga_timing_io_if #(.W(VW)) vb ();

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int hd, hf, hr, hbp, vd, vf, vr, vbp;
    } set_t;

    typedef struct {
        logic [HW-1:0] ht, hss, hse;
        logic [VW-1:0] vt, vss, vse;
        logic          v, e;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    logic prev_res = 1'b0;

    vga_timing_io dut (
        .clk_i          (clk),
        .arstn_i        (arstn),
        .load_i         (hb.load),
        .hd_i           (hb.d),
        .hf_i           (hb.f),
        .hr_i           (hb.r),
        .hb_i           (hb.b),
        .vd_i           (vb.d),
        .vf_i           (vb.f),
        .vr_i           (vb.r),
        .vb_i           (vb.b),
        .hd_o           (hb.d_q),
        .hf_o           (hb.f_q),
        .hr_o           (hb.r_q),
        .hb_o           (hb.b_q),
        .vd_o           (vb.d_q),
        .vf_o           (vb.f_q),
        .vr_o           (vb.r_q),
        .vb_o           (vb.b_q),
        .h_total_o      (hb.total),
        .h_sync_start_o (hb.sync_start),
        .h_sync_end_o   (hb.sync_end),
        .v_total_o      (vb.total),
        .v_sync_start_o (vb.sync_start),
        .v_sync_end_o   (vb.sync_end),
        .valid_o        (valid),
        .err_o          (err)
    );

    function automatic exp_t model(input set_t s);
        exp_t x;
        int   hs1, hs2, ht, vs1, vs2, vt;
        bit   ill;
        hs1 = s.hd + s.hf;  hs2 = hs1 + s.hr;  ht = hs2 + s.hbp;
        vs1 = s.vd + s.vf;  vs2 = vs1 + s.vr;  vt = vs2 + s.vbp;
        ill = (s.hd == 0) || (s.hr == 0) || (s.vd == 0) || (s.vr == 0) ||
              (ht > (1 << HW) - 1) || (vt > (1 << VW) - 1);
        x.ht  = ht[HW-1:0];  x.hss = hs1[HW-1:0]; x.hse = hs2[HW-1:0];
        x.vt  = vt[VW-1:0];  x.vss = vs1[VW-1:0]; x.vse = vs2[VW-1:0];
        x.v   = !ill;
        x.e   = ill;
        return x;
    endfunction

    // Scoreboard: every new result (rising valid|err) pops one expectation.
    always @(negedge clk) begin
        if ((valid || err) && !prev_res) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got valid=%0b err=%0b, required no result", valid, err);
            end else begin
                mx = sb.pop_front();
                if ({hb.total, hb.sync_start, hb.sync_end, vb.total, vb.sync_start, vb.sync_end, valid, err} !==
                    {mx.ht, mx.hss, mx.hse, mx.vt, mx.vss, mx.vse, mx.v, mx.e}) begin
                    bad++;
                    $display("FAIL result: got h=%0d/%0d/%0d v=%0d/%0d/%0d valid=%0b err=%0b, required h=%0d/%0d/%0d v=%0d/%0d/%0d valid=%0b err=%0b",
                             hb.total, hb.sync_start, hb.sync_end, vb.total, vb.sync_start, vb.sync_end, valid, err,
                             mx.ht, mx.hss, mx.hse, mx.vt, mx.vss, mx.vse, mx.v, mx.e);
                end
            end
        end
        prev_res = valid || err;
    end

    task automatic drive(input set_t s);
        hb.d = s.hd[HW-1:0];  hb.f = s.hf[HW-1:0];  hb.r = s.hr[HW-1:0];  hb.b = s.hbp[HW-1:0];
        vb.d = s.vd[VW-1:0];  vb.f = s.vf[VW-1:0];  vb.r = s.vr[VW-1:0];  vb.b = s.vbp[VW-1:0];
    endtask

    // Present a set with load high for one edge; returns at posedge+1 after edge k.
    task automatic do_load(input set_t s, input bit expect_result);
        drive(s);
        hb.load = 1'b1;
        vb.load = 1'b1;
        if (expect_result) sb.push_back(model(s));
        @(posedge clk); #1;
        hb.load = 1'b0;
        vb.load = 1'b0;
    endtask

    function automatic set_t mk(input int hd, hf, hr, hbp, vd, vf, vr, vbp);
        set_t s;
        s.hd = hd; s.hf = hf; s.hr = hr; s.hbp = hbp;
        s.vd = vd; s.vf = vf; s.vr = vr; s.vbp = vbp;
        return s;
    endfunction

    task automatic test_reset();
        arstn = 1'b0;
        drive(mk(800, 40, 128, 88, 600, 1, 4, 23));
        hb.load = 1'b1;
        vb.load = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (hb.d_q !== 11'd0 || vb.d_q !== 10'd0) begin
            bad++; $display("FAIL reset_fields: got hd=%0d vd=%0d, required 0", hb.d_q, vb.d_q);
        end
        total++;
        if (hb.total !== 11'd0 || vb.total !== 10'd0) begin
            bad++; $display("FAIL reset_derived: got ht=%0d vt=%0d, required 0", hb.total, vb.total);
        end
        total++;
        if (valid !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got valid=%0b err=%0b, required 0/0", valid, err);
        end
        @(posedge clk); #1;
        hb.load = 1'b0;
        vb.load = 1'b0;
        arstn   = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_800x600();
        do_load(mk(800, 40, 128, 88, 600, 1, 4, 23), 1'b1);
        @(negedge clk);
        total++;
        if ({hb.d_q, hb.f_q, hb.r_q, hb.b_q} !== {11'd800, 11'd40, 11'd128, 11'd88} ||
            {vb.d_q, vb.f_q, vb.r_q, vb.b_q} !== {10'd600, 10'd1, 10'd4, 10'd23}) begin
            bad++; $display("FAIL fields_k1: got h=%0d/%0d/%0d/%0d v=%0d/%0d/%0d/%0d, required 800/40/128/88 600/1/4/23",
                            hb.d_q, hb.f_q, hb.r_q, hb.b_q, vb.d_q, vb.f_q, vb.r_q, vb.b_q);
        end
        total++;
        if (valid !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL flags_k1: got valid=%0b err=%0b, required 0/0", valid, err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({hb.total, hb.sync_start, hb.sync_end} !== {11'd1056, 11'd840, 11'd968}) begin
            bad++; $display("FAIL h_derived_k2: got %0d/%0d/%0d, required 1056/840/968", hb.total, hb.sync_start, hb.sync_end);
        end
        total++;
        if ({vb.total, vb.sync_start, vb.sync_end} !== {10'd628, 10'd601, 10'd605}) begin
            bad++; $display("FAIL v_derived_k2: got %0d/%0d/%0d, required 628/601/605", vb.total, vb.sync_start, vb.sync_end);
        end
        total++;
        if (valid !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL flags_k2: got valid=%0b err=%0b, required 1/0", valid, err);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (valid !== 1'b1 || hb.total !== 11'd1056) begin
            bad++; $display("FAIL stable: got valid=%0b ht=%0d, required 1/1056", valid, hb.total);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        @(negedge clk); #2;
        arstn = 1'b0;
        #1;
        total++;
        if (hb.d_q !== 11'd0 || vb.d_q !== 10'd0 || hb.total !== 11'd0 || vb.sync_end !== 10'd0) begin
            bad++; $display("FAIL async_reset_data: got hd=%0d vd=%0d ht=%0d vse=%0d, required 0",
                            hb.d_q, vb.d_q, hb.total, vb.sync_end);
        end
        total++;
        if (valid !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL async_reset_flags: got valid=%0b err=%0b, required 0/0", valid, err);
        end
        @(posedge clk); #1;
        arstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_error(input string name, input set_t s);
        do_load(s, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (err !== 1'b1 || valid !== 1'b0) begin
            bad++; $display("FAIL %s: got valid=%0b err=%0b, required 0/1", name, valid, err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        drive(mk(800, 40, 128, 88, 600, 1, 4, 23));
        hb.load = 1'b1;
        vb.load = 1'b1;
        @(posedge clk); #1;
        do_load(mk(640, 16, 96, 48, 600, 1, 4, 23), 1'b1);
        @(negedge clk);
        total++;
        if (valid !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL b2b_k2: got valid=%0b err=%0b, required 0/0", valid, err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (hb.total !== 11'd800 || valid !== 1'b1) begin
            bad++; $display("FAIL b2b_k3: got ht=%0d valid=%0b, required 800/1", hb.total, valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_pipeline();
        do_load(mk(1024, 24, 136, 160, 768, 3, 6, 29), 1'b0);
        #2;
        arstn = 1'b0;
        #1;
        total++;
        if (hb.d_q !== 11'd0 || hb.total !== 11'd0 || valid !== 1'b0) begin
            bad++; $display("FAIL pipe_reset: got hd=%0d ht=%0d valid=%0b, required 0/0/0", hb.d_q, hb.total, valid);
        end
        @(posedge clk); #1;
        arstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (valid !== 1'b0 || err !== 1'b0 || vb.d_q !== 10'd0) begin
                bad++; $display("FAIL pipe_reset_hold%0d: got valid=%0b err=%0b vd=%0d, required 0/0/0", i, valid, err, vb.d_q);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        set_t s;
        for (int n = 0; n < 10; n++) begin
            s = mk($urandom_range(0, 1200), $urandom_range(0, 100), $urandom_range(0, 200), $urandom_range(0, 500),
                   $urandom_range(0, 700), $urandom_range(0, 20), $urandom_range(0, 10), $urandom_range(0, 200));
            do_load(s, 1'b1);
            repeat ($urandom_range(2, 4)) @(posedge clk);
            #1;
        end
        begin
            int budget;
            budget = 20;
            while (sb.size() != 0 && budget > 0) begin
                @(posedge clk); #1;
                budget--;
            end
            total++;
            if (sb.size() != 0) begin
                bad++; $display("FAIL drain: got %0d pending results, required 0", sb.size());
            end
        end
    endtask

    initial begin
        hb.load = 1'b0;
        vb.load = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        arstn = 1'b0;
        #1;
        test_reset();
        test_800x600();
        test_async_reset();
        test_error("overflow", mk(2000, 40, 10, 10, 600, 1, 4, 23));
        test_error("zero_vr", mk(800, 40, 128, 88, 600, 1, 0, 23));
        test_error("zero_hd", mk(0, 40, 128, 88, 600, 1, 4, 23));
        test_error("v_overflow", mk(800, 40, 128, 88, 1000, 10, 10, 10));
        test_back_to_back();
        test_reset_pipeline();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_io.md
# vga_timing_io

Registered holder for one VGA timing set: four horizontal and four vertical intervals. It captures the intervals on a load strobe, derives line/frame totals and sync-pulse boundaries, and flags inconsistent sets. It sits between the resolution memory (`vga_res_mem`) and the pixel/line counters, which consume only its registered outputs.

## Interface
Parameters:
- `H_W`, default `VGA_MAX_H_WIDTH` (11): width of all horizontal quantities.
- `V_W`, default `VGA_MAX_V_WIDTH` (10): width of all vertical quantities.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_i`, in, 1: clock.
  - `arstn_i`, in, 1: reset, asynchronous, active-low.
- `load_i`, in, 1: capture strobe.
- `hd_i`, `hf_i`, `hr_i`, `hb_i`, in, `H_W` each: horizontal display, front porch, retrace (sync), back porch, in pixels.
- `vd_i`, `vf_i`, `vr_i`, `vb_i`, in, `V_W` each: vertical display, front porch, retrace, back porch, in lines.
- `hd_o` … `vb_o`, out, `H_W`/`V_W`: registered copies of the eight inputs.
- `h_total_o`, out, `H_W`: hd+hf+hr+hb.
- `h_sync_start_o`, out, `H_W`: hd+hf.
- `h_sync_end_o`, out, `H_W`: hd+hf+hr.
- `v_total_o`, `v_sync_start_o`, `v_sync_end_o`, out, `V_W`: vertical equivalents.
- `valid_o`, out, 1: derived outputs consistent with the field outputs, and the set is legal.
- `err_o`, out, 1: the last loaded set is illegal.

## Operation
- When `load_i`=1 at an edge, all eight inputs are captured into the field registers. Otherwise the registers hold.
- Derived values are computed from the field registers at `H_W+2` / `V_W+2` bits, then registered, truncated to `H_W` / `V_W`.
- A set is illegal if any of the following holds:
  - `hd`, `hr`, `vd` or `vr` is zero;
  - the full-width `h_total` exceeds 2^`H_W`−1;
  - the full-width `v_total` exceeds 2^`V_W`−1.
- Result stage:
  - `err_o` = illegal;
  - `valid_o` = not illegal.
  - Both are produced only once derived values correspond to the latest load.
- Any `load_i` clears `valid_o` and `err_o` on the next edge. No partial or stale result is ever flagged valid.
- Back-to-back loads: the latest load wins, and results appear two cycles after the last strobe.
- Reset:
  - all field, derived, `valid_o` and `err_o` registers go to 0 immediately;
  - `load_i` is ignored while `arstn_i`=0;
  - reset mid-computation discards the pending result.

## Timing
- `load_i` sampled high at edge k:
  - k+1: field outputs hold the new values; `valid_o`=`err_o`=0.
  - k+2: derived outputs updated; exactly one of `valid_o` or `err_o` is 1.
- Outputs stay stable until the next `load_i` or reset.
- Two-stage latency is fixed and does not depend on the data.

## Structure
- Shared package `vga_pkg` holds:
  - `VGA_MAX_H_WIDTH` (11) and `VGA_MAX_V_WIDTH` (10);
  - the `vga_resolution_e` enum, including `VGA_RES_800_600`;
  - `VGA_RES_NUM`.
- One sub-module, `vga_timing_axis`, parameterised by width:
  - contains the four field registers, adders, derived registers and the per-axis illegal flag;
  - instantiated once for H and once for V.
- The top level ORs the two illegal flags and owns the valid/err pipeline bit.

## Test plan
- **Reset:** assert `arstn_i` mid-cycle → all outputs 0 immediately, `valid_o`=0.
- **800×600 load:** hd/hf/hr/hb=800/40/128/88, vd/vf/vr/vb=600/1/4/23 with `load_i` at k. Required response:
  - at k+1: fields updated, `valid_o`=0;
  - at k+2: `h_total`=1056, `h_sync_start`=840, `h_sync_end`=968, `v_total`=628, `v_sync_start`=601, `v_sync_end`=605, `valid_o`=1, `err_o`=0.
- **Overflow:** hd=2000, hf=40, hr=10, hb=10 → at k+2 `err_o`=1, `valid_o`=0.
- **Zero retrace:** vr=0 with otherwise legal values → `err_o`=1.
- **Back-to-back loads:** 800×600 at k, then hd=640/hf=16/hr=96/hb=48 at k+1. Required response:
  - `valid_o` stays 0 at k+2;
  - at k+3: `h_total`=800, `valid_o`=1.
- **Reset during pipeline:** load at k, `arstn_i` low during k+1 → `valid_o` never asserts and all outputs are 0.
